// File: rtl/bitwise16_arbiter.sv
// bitwise16_arbiter: round-robin front end that shares one AND/OR/XOR/NAND
// unit between two valid/ready requesters. One operation is in flight at a
// time. The result is returned on a single registered port and tagged with
// the id of the requester that issued it.
module bitwise16_arbiter #(
   parameter int unsigned WIDTH    = 16,
   parameter bit          PRI_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   logic [1:0]       r_state;
   logic             r_ptr;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_id;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_data;

   logic             w_idle;
   logic             w_grant;
   logic             w_acc0;
   logic             w_acc1;
   logic [WIDTH-1:0] w_result;

   // Grant: a lone requester wins outright; contention or silence defers to the pointer
   always_comb begin
      w_grant = r_ptr;
      if (req0_valid != req1_valid) begin
         w_grant = req1_valid;
      end
   end

   assign w_idle     = (r_state == ST_IDLE);
   assign req0_ready = w_idle && !w_grant;
   assign req1_ready = w_idle &&  w_grant;
   assign w_acc0     = req0_valid && req0_ready;
   assign w_acc1     = req1_valid && req1_ready;

   // Bitwise function of the latched operation
   always_comb begin
      w_result = '0;
      case (r_op)
         OP_AND:  w_result = r_a & r_b;
         OP_OR:   w_result = r_a | r_b;
         OP_XOR:  w_result = r_a ^ r_b;
         OP_NAND: w_result = ~(r_a & r_b);
      endcase
   end

   // Sequencer: operand latch on accept, result register in EXEC, hold in RESP
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= PRI_INIT;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_id        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_acc0 || w_acc1) begin
                  r_op    <= w_acc1 ? req1_op : req0_op;
                  r_a     <= w_acc1 ? req1_a  : req0_a;
                  r_b     <= w_acc1 ? req1_b  : req0_b;
                  r_id    <= w_acc1;
                  r_ptr   <= !w_acc1;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_rsp_data  <= w_result;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign busy      = !w_idle;

endmodule

// File: tb/tb_bitwise16_arbiter.sv
// Testbench for bitwise16_arbiter: scenario tasks with inline checks against
// a behavioural model of the grant rule, the bitwise function and a queue of
// expected responses.
module tb_bitwise16_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [1:0]  req0_op;
   logic [15:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [1:0]  req1_op;
   logic [15:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [15:0] rsp_data;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit m_ptr    = 1'b0;

   typedef struct {
      bit          id;
      logic [15:0] d;
   } exp_t;
   exp_t exp_q[$];

   bitwise16_arbiter #(.WIDTH(16), .PRI_INIT(1'b0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   function automatic bit ref_grant(input bit v0, input bit v1, input bit ptr);
      if (v0 && !v1) return 1'b0;
      if (v1 && !v0) return 1'b1;
      return ptr;
   endfunction

   // Driver only: single request from one requester, rsp_ready held high.
   task automatic issue(input bit id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] data, output bit rid, output int lat,
                        output int busy_cnt, output bit to);
      int w;
      to = 1'b0; lat = 0; busy_cnt = 0; data = '0; rid = 1'b0;
      rsp_ready = 1'b1;
      req0_valid = !id; req1_valid = id;
      req0_op = op; req0_a = a; req0_b = b;
      req1_op = op; req1_a = a; req1_b = b;
      #1;
      w = 0;
      while (!(id ? req1_ready : req0_ready) && w < 20) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 20) begin
         to = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (busy) busy_cnt++;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
         if (busy) busy_cnt++;
      end
      if (!rsp_valid) begin
         to = 1'b1;
         return;
      end
      data = rsp_data; rid = rsp_id;
      @(posedge clk); #1;
      if (busy) busy_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op = '0; req0_a = '0; req0_b = '0;
      req1_op = '0; req1_a = '0; req1_b = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      n_checks++; if (rsp_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_ready got %b want 01", {req1_ready, req0_ready}); end
      req1_valid = 1'b1; #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++; $display("FAIL reset_lone_req1 got %b want 10", {req1_ready, req0_ready}); end
      req1_valid = 1'b0;
      m_ptr = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_and();
      logic [15:0] d; bit rid, to; int lat, bc;
      issue(1'b0, 2'b00, 16'hF0F0, 16'hFF00, d, rid, lat, bc, to);
      m_ptr = 1'b1;
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout got %b want 0", to); end
      n_checks++; if (d !== 16'hF000) begin n_fail++; $display("FAIL single_data got %h want f000", d); end
      n_checks++; if (rid !== 1'b0) begin n_fail++; $display("FAIL single_id got %b want 0", rid); end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL single_latency got %0d want 1", lat); end
      n_checks++; if (bc !== 2) begin n_fail++; $display("FAIL single_busy_cycles got %0d want 2", bc); end
   endtask

   task automatic test_req1_ops();
      logic [15:0] exp_tab [4];
      logic [15:0] d; bit rid, to; int lat, bc;
      exp_tab[0] = 16'h0AA0; exp_tab[1] = 16'hAFFA; exp_tab[2] = 16'hA55A; exp_tab[3] = 16'hF55F;
      for (int k = 0; k < 4; k++) begin
         issue(1'b1, 2'(k), 16'hAAAA, 16'h0FF0, d, rid, lat, bc, to);
         m_ptr = 1'b0;
         n_checks++; if (to !== 1'b0 || d !== exp_tab[k]) begin n_fail++; $display("FAIL req1_op%0d_data got %h want %h (timeout %b)", k, d, exp_tab[k], to); end
         n_checks++; if (rid !== 1'b1) begin n_fail++; $display("FAIL req1_op%0d_id got %b want 1", k, rid); end
      end
   endtask

   task automatic test_fairness();
      logic [1:0]  op [2];
      logic [15:0] a [2];
      logic [15:0] b [2];
      logic [15:0] expd;
      bit w;
      for (int i = 0; i < 2; i++) begin
         op[i] = 2'($urandom_range(0, 3)); a[i] = 16'($urandom); b[i] = 16'($urandom);
      end
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req0_op = op[0]; req0_a = a[0]; req0_b = b[0];
         req1_op = op[1]; req1_a = a[1]; req1_b = b[1];
         req0_valid = 1'b1; req1_valid = 1'b1;
         #1;
         w = ref_grant(1'b1, 1'b1, m_ptr);
         n_checks++; if (w !== k[0]) begin n_fail++; $display("FAIL fair_model_seq%0d got %b want %b", k, w, k[0]); end
         n_checks++; if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL fair_ready%0d got %b want %b", k, {req1_ready, req0_ready}, (w ? 2'b10 : 2'b01)); end
         @(posedge clk); #1;
         m_ptr = !w;
         expd = ref_f(op[w], a[w], b[w]);
         op[w] = 2'($urandom_range(0, 3)); a[w] = 16'($urandom); b[w] = 16'($urandom);
         if (w) begin req1_op = op[1]; req1_a = a[1]; req1_b = b[1]; end
         else   begin req0_op = op[0]; req0_a = a[0]; req0_b = b[0]; end
         n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL fair_exec_ready%0d got %b want 00", k, {req1_ready, req0_ready}); end
         @(posedge clk); #1;
         n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== w || rsp_data !== expd) begin n_fail++; $display("FAIL fair_rsp%0d got v=%b id=%b d=%h want v=1 id=%b d=%h", k, rsp_valid, rsp_id, rsp_data, w, expd); end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [15:0] a, b, expd;
      a = 16'($urandom); b = 16'($urandom);
      expd = ref_f(2'b10, a, b);
      rsp_ready = 1'b0;
      req0_op = 2'b10; req0_a = a; req0_b = b; req0_valid = 1'b1; req1_valid = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      m_ptr = 1'b1;
      @(posedge clk); #1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== expd) begin n_fail++; $display("FAIL bp_hold%0d got v=%b id=%b d=%h want v=1 id=0 d=%h", c, rsp_valid, rsp_id, rsp_data, expd); end
         n_checks++; if ({req1_ready, req0_ready, busy} !== 3'b001) begin n_fail++; $display("FAIL bp_ready_busy%0d got %b want 001", c, {req1_ready, req0_ready, busy}); end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got v=%b busy=%b want 0 0", rsp_valid, busy); end
      n_checks++; if (rsp_data !== expd) begin n_fail++; $display("FAIL bp_data_kept got %h want %h", rsp_data, expd); end
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_ready_ignored got v=%b busy=%b want 0 0", rsp_valid, busy); end
   endtask

   task automatic test_walking_ones();
      logic [15:0] one, a, b, expd, d;
      bit rid, to; int lat, bc;
      one = 16'd1;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            a = one << i; b = one << j;
            expd = (i == j) ? a : 16'h0000;
            issue(1'b0, 2'b00, a, b, d, rid, lat, bc, to);
            m_ptr = 1'b1;
            n_checks++; if (to !== 1'b0 || d !== expd || rid !== 1'b0) begin n_fail++; $display("FAIL walk_i%0d_j%0d got d=%h id=%b to=%b want d=%h id=0", i, j, d, rid, to, expd); end
         end
      end
   endtask

   task automatic test_random();
      logic [1:0]  op [2];
      logic [15:0] a [2];
      logic [15:0] b [2];
      exp_t e;
      bit v0, v1, w;
      int pat, hold;
      for (int n = 0; n < 60; n++) begin
         pat = $urandom_range(0, 2);
         v0 = (pat != 1); v1 = (pat != 0);
         for (int i = 0; i < 2; i++) begin
            op[i] = 2'($urandom_range(0, 3)); a[i] = 16'($urandom); b[i] = 16'($urandom);
         end
         req0_op = op[0]; req0_a = a[0]; req0_b = b[0]; req0_valid = v0;
         req1_op = op[1]; req1_a = a[1]; req1_b = b[1]; req1_valid = v1;
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         w = ref_grant(v0, v1, m_ptr);
         n_checks++; if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rnd%0d_ready got %b want %b", n, {req1_ready, req0_ready}, (w ? 2'b10 : 2'b01)); end
         @(posedge clk); #1;
         req0_valid = 1'b0; req1_valid = 1'b0;
         e.id = w; e.d = ref_f(op[w], a[w], b[w]);
         exp_q.push_back(e);
         m_ptr = !w;
         n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_exec got busy=%b v=%b want 1 0", n, busy, rsp_valid); end
         @(posedge clk); #1;
         rsp_ready = 1'b0;
         hold = $urandom_range(0, 3);
         repeat (hold) begin @(posedge clk); #1; end
         e = exp_q.pop_front();
         n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.d) begin n_fail++; $display("FAIL rnd%0d_rsp got v=%b id=%b d=%h want v=1 id=%b d=%h", n, rsp_valid, rsp_id, rsp_data, e.id, e.d); end
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_done got v=%b busy=%b want 0 0", n, rsp_valid, busy); end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] d; bit rid, to; int lat, bc;
      issue(1'b0, 2'b01, 16'h1234, 16'h8001, d, rid, lat, bc, to);
      m_ptr = 1'b1;
      n_checks++; if (to !== 1'b0 || d !== 16'h9235) begin n_fail++; $display("FAIL mid_pre_op got %h want 9235 (timeout %b)", d, to); end
      req0_op = 2'b11; req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_valid = 1'b1; req1_valid = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_exec got busy=%b want 1", busy); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_ptr = 1'b0;
      n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_reset got v=%b busy=%b want 0 0", rsp_valid, busy); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp%0d got %b want 0", c, rsp_valid); end
      end
      req0_op = 2'b00; req0_a = 16'h3C3C; req0_b = 16'hFFFF; req0_valid = 1'b1;
      req1_op = 2'b01; req1_a = 16'h0000; req1_b = 16'h0000; req1_valid = 1'b1;
      #1;
      n_checks++; if ({req1_ready, req0_ready} !== (ref_grant(1'b1, 1'b1, m_ptr) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL mid_ptr_restored got %b want 01", {req1_ready, req0_ready}); end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h3C3C) begin n_fail++; $display("FAIL mid_next_rsp got v=%b id=%b d=%h want v=1 id=0 d=3c3c", rsp_valid, rsp_id, rsp_data); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single_and();
      test_req1_ops();
      test_fairness();
      test_backpressure();
      test_walking_ones();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog simulation time limit reached, checks=%0d", n_checks);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
